// File: rtl/relay_pkg.sv
// Shared types and helpers for the credit-based relay link.
// Holds the transmitter state encoding and width functions.
package relay_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_ERR   = 2'd2
    } relay_state_e;

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    // A valid-only stage still needs a one-bit payload port.
    function automatic int pipe_w(input int dw);
        return (dw > 0) ? dw : 1;
    endfunction

endpackage

// File: rtl/relay_pipe_stage.sv
// One register stage of the relay link: valid bit plus an optional
// payload that only loads when the incoming valid is set.
module relay_pipe_stage
    import relay_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              valid_i,
    input  logic [pipe_w(DATA_WIDTH)-1:0]     data_i,
    output logic                              valid_o,
    output logic [pipe_w(DATA_WIDTH)-1:0]     data_o
);

    (* dont_touch = "true" *) logic valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    assign valid_o = valid_q;

    generate
        if (DATA_WIDTH > 0) begin : g_data
            (* dont_touch = "true" *) logic [DATA_WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (valid_i) begin
                    data_q <= data_i;
                end
            end

            assign data_o = data_q;
        end else begin : g_nodata
            logic unused_data;
            assign unused_data = ^data_i;
            assign data_o      = '0;
        end
    endgenerate

endmodule

// File: rtl/relay_credit_tx.sv
// Credit-based transmitter: launches payloads down a registered link
// and tracks receiver buffer credits returned on a matching path.
module relay_credit_tx
    import relay_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 2,
    parameter int CREDITS    = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            if_full_n,
    input  logic                            if_write_ce,
    input  logic                            if_write,
    input  logic [DATA_WIDTH-1:0]           if_din,
    output logic                            link_valid,
    output logic [DATA_WIDTH-1:0]           link_data,
    input  logic                            link_credit,
    output logic [credit_w(CREDITS)-1:0]    credit_avail,
    output logic                            err_overflow
);

    localparam int            CW   = credit_w(CREDITS);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic          push;
    logic          overflow;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    relay_state_e  state_q;
    relay_state_e  state_d;

    (* dont_touch = "true" *) logic                  launch_v_q;
    (* dont_touch = "true" *) logic [DATA_WIDTH-1:0] launch_d_q;
    (* dont_touch = "true" *) logic                  credit_q;

    logic                  fwd_v [LEVEL+1];
    logic [DATA_WIDTH-1:0] fwd_d [LEVEL+1];
    logic                  ret_v [LEVEL+1];

    assign push = if_write & if_write_ce & if_full_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            launch_v_q <= 1'b0;
        end else begin
            launch_v_q <= push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            launch_d_q <= if_din;
        end
    end

    assign fwd_v[0] = launch_v_q;
    assign fwd_d[0] = launch_d_q;
    assign ret_v[0] = link_credit;

    generate
        for (genvar i = 0; i < LEVEL; i++) begin : g_fwd
            relay_pipe_stage #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_fwd (
                .clk     (clk),
                .rst_n   (reset),
                .valid_i (fwd_v[i]),
                .data_i  (fwd_d[i]),
                .valid_o (fwd_v[i+1]),
                .data_o  (fwd_d[i+1])
            );
        end

        for (genvar i = 0; i < LEVEL; i++) begin : g_ret
            logic unused_ret_d;

            relay_pipe_stage #(
                .DATA_WIDTH (0)
            ) u_ret (
                .clk     (clk),
                .rst_n   (reset),
                .valid_i (ret_v[i]),
                .data_i  (1'b0),
                .valid_o (ret_v[i+1]),
                .data_o  (unused_ret_d)
            );
        end
    endgenerate

    assign link_valid = fwd_v[LEVEL];
    assign link_data  = fwd_d[LEVEL];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q <= 1'b0;
        end else begin
            credit_q <= ret_v[LEVEL];
        end
    end

    // A credit landing on a full counter is dropped and flagged.
    assign overflow = credit_q & ~push & (cnt_q == CMAX);

    always_comb begin
        cnt_d = cnt_q;
        if (push & ~credit_q) begin
            cnt_d = cnt_q - CW'(1);
        end else if (credit_q & ~push & (cnt_q != CMAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CMAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign if_full_n    = (cnt_q != '0);
    assign credit_avail = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (cnt_d == '0) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (credit_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (overflow) begin
            state_d = ST_ERR;
        end
    end

    always_comb begin
        err_overflow = (state_q == ST_ERR);
    end

endmodule
